// File: rtl/rv32i_io_pkg.sv
// ============================================================================
// Module      : rv32i_io_pkg
// Description : UART transmitter IO map, STATUS bit positions and FSM states.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rv32i_io_pkg;

    // Word addresses (byte address >> 2) as seen on io_addr[31:2]
    localparam logic [29:0] ADDR_TXDATA  = 30'h0000_2004;   // byte 0x8010
    localparam logic [29:0] ADDR_STATUS  = 30'h0000_2005;   // byte 0x8014
    localparam logic [29:0] ADDR_BAUDDIV = 30'h0000_2006;   // byte 0x8018

    localparam int unsigned STAT_OVERFLOW = 4;
    localparam int unsigned STAT_FULL     = 3;
    localparam int unsigned STAT_EMPTY    = 2;
    localparam int unsigned STAT_BUSY     = 1;
    localparam int unsigned STAT_ACTIVE   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/rv32i_sync_fifo.sv
// ============================================================================
// Module      : rv32i_sync_fifo
// Description : Single-clock FIFO, first-word fall-through read port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rv32i_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still takes a push when a pop frees a slot on the same edge
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/rv32i_io_uart_tx.sv
// ============================================================================
// Module      : rv32i_io_uart_tx
// Description : Memory-mapped 8N1 UART transmitter with FIFO and baud divisor.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rv32i_io_uart_tx
    import rv32i_io_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [15:0] BAUD_DIV_RST = 16'd87
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_we,
    input  logic [31:2] io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_t state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;
    logic [31:0] rdata_q, rdata_d;

    logic          wr_txdata, wr_status, wr_baud;
    logic          fifo_pop, fifo_full, fifo_empty, load;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [4:0]    status;
    logic          unused_bits;

    assign wr_txdata = io_we && (io_addr == ADDR_TXDATA);
    assign wr_status = io_we && (io_addr == ADDR_STATUS);
    assign wr_baud   = io_we && (io_addr == ADDR_BAUDDIV);

    assign unused_bits = ^{io_wdata[31:16], fifo_count};

    rv32i_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_txdata),
        .wdata_i (io_wdata[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign tx_busy  = (state_q != IDLE) || !fifo_empty;
    assign uart_tx  = tx_q;
    assign io_rdata = rdata_q;

    always_comb begin
        status                = '0;
        status[STAT_OVERFLOW] = ovf_q;
        status[STAT_FULL]     = fifo_full;
        status[STAT_EMPTY]    = fifo_empty;
        status[STAT_BUSY]     = tx_busy;
        status[STAT_ACTIVE]   = (state_q != IDLE);
    end

    always_comb begin
        baud_d  = baud_q;
        ovf_d   = ovf_q;
        rdata_d = '0;
        if (wr_baud) begin
            baud_d = (io_wdata[15:0] < 16'd2) ? 16'd2 : io_wdata[15:0];
        end
        if (wr_txdata && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end else if (wr_status && io_wdata[STAT_OVERFLOW]) begin
            ovf_d = 1'b0;
        end
        if (io_addr == ADDR_STATUS) begin
            rdata_d = {27'b0, status};
        end else if (io_addr == ADDR_BAUDDIV) begin
            rdata_d = {16'b0, baud_q};
        end
    end

    // Each state holds for div cycles; the divisor is latched only at frame start
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        div_d    = div_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                load = !fifo_empty;
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    state_d = DATA;
                    cnt_d   = div_q - 16'd1;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = div_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == 16'd0) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        if (load) begin
            fifo_pop = 1'b1;
            state_d  = START;
            div_d    = baud_q;
            cnt_d    = baud_q - 16'd1;
            shift_d  = fifo_rdata;
            tx_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= BAUD_DIV_RST;
            div_q   <= BAUD_DIV_RST;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_io_uart_tx.sv
// ============================================================================
// Module      : tb_rv32i_io_uart_tx
// Description : Randomised and directed bench against a frame-level UART model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_rv32i_io_uart_tx;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] BAUD_RST = 16'd87;
    localparam logic [29:0] A_TX     = 30'h0000_2004;
    localparam logic [29:0] A_ST     = 30'h0000_2005;
    localparam logic [29:0] A_BD     = 30'h0000_2006;
    localparam logic [29:0] A_UN     = 30'h0000_2007;

    logic        clk;
    logic        reset;
    logic        io_we;
    logic [31:2] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        uart_tx;
    logic        tx_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt = 0;

    // Reference model: queue of pending bytes plus the frame on the line
    logic [7:0]  m_q[$];
    bit          m_act;
    int          m_el;
    int          m_div;
    logic [7:0]  m_byte;
    logic [15:0] m_baud;
    bit          m_ovf;
    logic [31:0] m_rdata;

    rv32i_io_uart_tx #(
        .FIFO_DEPTH   (DEPTH),
        .BAUD_DIV_RST (BAUD_RST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .io_we    (io_we),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .uart_tx  (uart_tx),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int idx;
        if (!m_act) return 1'b1;
        idx = m_el / m_div;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_byte[idx-1];
    endfunction

    function automatic logic exp_busy();
        return m_act || (m_q.size() != 0);
    endfunction

    task automatic model_step(input bit rst, input bit we, input logic [29:0] a, input logic [31:0] d);
        logic [4:0] st;
        if (rst) begin
            m_q.delete();
            m_act   = 1'b0;
            m_el    = 0;
            m_ovf   = 1'b0;
            m_baud  = BAUD_RST;
            m_rdata = '0;
            return;
        end
        st = {m_ovf, m_q.size() == DEPTH, m_q.size() == 0, exp_busy(), m_act};
        if (a == A_ST)      m_rdata = {27'b0, st};
        else if (a == A_BD) m_rdata = {16'b0, m_baud};
        else                m_rdata = '0;
        if (m_act) begin
            m_el++;
            if (m_el == 10 * m_div) m_act = 1'b0;
        end
        if (!m_act && m_q.size() != 0) begin
            m_byte = m_q.pop_front();
            m_act  = 1'b1;
            m_el   = 0;
            m_div  = int'(m_baud);
        end
        if (we) begin
            if (a == A_TX) begin
                if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
                else m_ovf = 1'b1;
            end else if (a == A_ST) begin
                if (d[4]) m_ovf = 1'b0;
            end else if (a == A_BD) begin
                m_baud = (d[15:0] < 16'd2) ? 16'd2 : d[15:0];
            end
        end
    endtask

    // Compare outputs of the previous edge, then present inputs for the next one
    task automatic step(input bit rst, input bit we, input logic [29:0] a, input logic [31:0] d);
        @(negedge clk);
        check_eq("uart_tx", {31'b0, uart_tx}, {31'b0, exp_tx()});
        check_eq("tx_busy", {31'b0, tx_busy}, {31'b0, exp_busy()});
        check_eq("io_rdata", io_rdata, m_rdata);
        if (tx_busy) busy_cnt++;
        reset    = rst;
        io_we    = we;
        io_addr  = a;
        io_wdata = d;
        model_step(rst, we, a, d);
    endtask

    task automatic expect_after(input string tag, input logic [31:0] exp);
        @(posedge clk);
        #1;
        check_eq(tag, io_rdata, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, A_ST, 32'h0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, A_ST, 32'h0);
        #1;
        check_eq("rst_tx_now", {31'b0, uart_tx}, 32'h1);
        check_eq("rst_busy_now", {31'b0, tx_busy}, 32'h0);
        check_eq("rst_rdata_now", io_rdata, 32'h0);
        step(1'b1, 1'b0, A_ST, 32'h0);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && exp_busy(); i++) step(1'b0, 1'b0, A_ST, 32'h0);
        @(posedge clk);
        #1;
        check_eq("drain_idle", {31'b0, tx_busy}, 32'h0);
    endtask

    function automatic logic [29:0] rand_rd_addr();
        case ($urandom_range(0, 4))
            0:       return A_TX;
            1:       return A_ST;
            2:       return A_BD;
            3:       return A_UN;
            default: return 30'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        reset    = 1'b0;
        io_we    = 1'b0;
        io_addr  = '0;
        io_wdata = '0;
        model_step(1'b1, 1'b0, A_ST, 32'h0);
        #1 reset = 1'b1;

        // Reset state and default divisor
        step(1'b1, 1'b0, A_ST, 32'h0);
        step(1'b1, 1'b0, A_ST, 32'h0);
        check_eq("rst_tx", {31'b0, uart_tx}, 32'h1);
        check_eq("rst_busy", {31'b0, tx_busy}, 32'h0);
        check_eq("rst_rdata", io_rdata, 32'h0);
        step(1'b0, 1'b0, A_BD, 32'h0);
        expect_after("rst_bauddiv", 32'd87);

        // Single 0xA5 frame at the reset divisor
        busy_cnt = 0;
        step(1'b0, 1'b1, A_TX, 32'hA5);
        idle(900);
        check_eq("frame_busy_len", busy_cnt, 32'd871);

        // Overflow on the sixth back-to-back write, then clear it
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, A_TX, 32'h10 + k);
        step(1'b0, 1'b0, A_ST, 32'h0);
        expect_after("ovf_set_status", 32'h1B);
        step(1'b0, 1'b1, A_ST, 32'h10);
        step(1'b0, 1'b0, A_ST, 32'h0);
        expect_after("ovf_clear_status", 32'h0B);
        drain(6000);

        // Divisor change mid-frame applies to the next frame only
        step(1'b0, 1'b1, A_TX, 32'h5A);
        step(1'b0, 1'b1, A_TX, 32'hC3);
        idle(300);
        step(1'b0, 1'b1, A_BD, 32'h4);
        step(1'b0, 1'b0, A_BD, 32'h0);
        expect_after("bauddiv_4", 32'h4);
        drain(2000);

        // Divisor clamp, unmapped and TXDATA reads
        step(1'b0, 1'b1, A_BD, 32'h0);
        step(1'b0, 1'b0, A_BD, 32'h0);
        expect_after("bauddiv_min", 32'h2);
        step(1'b0, 1'b0, A_UN, 32'h0);
        expect_after("unmapped_rd", 32'h0);
        step(1'b0, 1'b0, A_TX, 32'h0);
        expect_after("txdata_rd", 32'h0);
        step(1'b0, 1'b1, A_UN, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, A_BD, 32'h0);
        expect_after("unmapped_wr_ignored", 32'h2);

        // Reset during data bit 3
        step(1'b0, 1'b1, A_BD, 32'd87);
        step(1'b0, 1'b1, A_TX, 32'hF0);
        idle(390);
        check_eq("in_data_bit3", {31'b0, uart_tx}, 32'h0);
        do_reset();
        step(1'b0, 1'b0, A_ST, 32'h0);
        expect_after("post_rst_status", 32'h4);
        step(1'b0, 1'b0, A_BD, 32'h0);
        expect_after("post_rst_bauddiv", 32'd87);

        // Full FIFO: push on the same edge as a pop is accepted
        step(1'b0, 1'b1, A_BD, 32'h2);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, A_TX, 32'h60 + k);
        for (int i = 0; i < 100 && !(m_act && m_el == 10 * m_div - 1); i++)
            step(1'b0, 1'b0, A_ST, 32'h0);
        check_eq("pop_edge_reached", {31'b0, (m_act && m_el == 10 * m_div - 1)}, 32'h1);
        step(1'b0, 1'b1, A_TX, 32'h3C);
        step(1'b0, 1'b0, A_ST, 32'h0);
        expect_after("full_push_pop", 32'h0B);
        drain(500);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0)       do_reset();
            else if (r < 50)  step(1'b0, 1'b1, A_TX, $urandom);
            else if (r < 56)  step(1'b0, 1'b1, A_ST, $urandom);
            else if (r < 62)  step(1'b0, 1'b1, A_BD, {16'($urandom), 16'($urandom_range(0, 5))});
            else if (r < 66)  step(1'b0, 1'b1, A_UN, $urandom);
            else              step(1'b0, 1'b0, rand_rd_addr(), $urandom);
        end
        drain(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv32i_io_uart_tx.md
RV32I_IO_UART_TX -- requirements
Module: rv32i_io_uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set transmit FIFO entries; legal values are powers of two, 2..16.
REQ-002 Parameter BAUD_DIV_RST, default 16'd87, SHALL set the reset value of the baud divisor (10 MHz / 115200).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 io_we  input  1  SHALL be the IO write enable from the memory stage.
REQ-006 io_addr  input  30 [31:2]  SHALL be the IO word address, used for both read and write.
REQ-007 io_wdata  input  32  SHALL be the IO write data.
REQ-008 io_rdata  output  32  SHALL be the registered read data to the memory/writeback stages.
REQ-009 uart_tx  output  1  SHALL be the serial line, 8N1, LSB first, idle high.
REQ-010 tx_busy  output  1  SHALL be high while a frame is on the line or the FIFO is non-empty.

Function
REQ-011 Byte 0x8010 (TXDATA) SHALL push io_wdata[7:0] on a write when not full; a read SHALL return 0.
REQ-012 Byte 0x8014 (STATUS) SHALL read {27'b0, overflow, full, empty, tx_busy, shifter_active}.
REQ-013 A write to STATUS with io_wdata[4]=1 SHALL clear overflow; all other STATUS bits SHALL be read-only.
REQ-014 Byte 0x8018 (BAUDDIV) SHALL read and write io_wdata[15:0]; upper bits SHALL read 0.
REQ-015 A write of BAUDDIV < 2 SHALL be stored as 2.
REQ-016 A new BAUDDIV value SHALL take effect at the next frame start, never mid-frame.
REQ-017 io_rdata SHALL reflect io_addr one cycle after presentation, matching data RAM read latency.
REQ-018 Unmapped addresses SHALL read 0, and writes to them SHALL be ignored.
REQ-019 Reads SHALL have no side effects.
REQ-020 A TXDATA write when full SHALL drop the byte and set sticky overflow; FIFO contents SHALL be unchanged.
REQ-021 A push and a pop in the same cycle SHALL both succeed when not full, leaving the count unchanged.
REQ-022 When full, a same-cycle push and pop SHALL accept the push.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a count of width clog2(FIFO_DEPTH)+1.
REQ-024 FSM IDLE->START SHALL occur when the FIFO is non-empty, popping the byte and latching the divisor the same cycle.
REQ-025 START SHALL drive uart_tx low for div cycles.
REQ-026 DATA SHALL drive 8 bits LSB first, div cycles each, using a 3-bit bit counter.
REQ-027 STOP SHALL drive uart_tx high for div cycles, then go to START if the FIFO is non-empty, else IDLE, with no idle gap between back-to-back frames.
REQ-028 Each frame SHALL therefore last exactly 10*div cycles.
REQ-029 The baud counter SHALL count div-1 down to 0 and advance the bit on 0.
REQ-030 uart_tx SHALL be driven from a flop (glitch-free).

Reset
REQ-031 While reset is high, the following SHALL hold: uart_tx=1, tx_busy=0, io_rdata=0, FSM=IDLE, FIFO empty, overflow=0, BAUDDIV=BAUD_DIV_RST.
REQ-032 Reset mid-frame SHALL abort the frame immediately, returning uart_tx high and discarding FIFO contents.
REQ-033 After reset deasserts, the first TXDATA write SHALL be accepted on the first clock edge.

Structure
REQ-034 Package rv32i_io_pkg SHALL hold the IO address constants (TXDATA, STATUS, BAUDDIV), the STATUS bit indices, and the FSM enum typedef uart_state_t {IDLE, START, DATA, STOP}.
REQ-035 One sub-module, rv32i_sync_fifo (parameterised width and depth; push, pop, full, empty, count), SHALL implement the buffer.
REQ-036 Decode, registers and FSM SHALL reside in the top module.

Verification
REQ-037 Reset, write 0xA5 to TXDATA, BAUDDIV=87 -> uart_tx low one cycle later for 87 cycles, then bits 1,0,1,0,0,1,0,1, then high; tx_busy drops 870 cycles after the pop.
REQ-038 Write 6 bytes back-to-back with FIFO_DEPTH=4 -> 5 bytes accepted (1 already popped), 6th dropped, STATUS bit4=1; write STATUS 0x10 -> bit4=0.
REQ-039 Write BAUDDIV=4 mid-frame of a two-byte burst -> first frame 870 cycles, second frame 40 cycles, no gap.
REQ-040 Write BAUDDIV=0, read BAUDDIV -> 0x00000002; read 0x801C -> 0x00000000, one cycle after the address.
REQ-041 Assert reset during DATA bit 3 -> uart_tx=1 and STATUS=0x00000004 (empty) after release; BAUDDIV=87.
REQ-042 With FIFO full, simultaneous pop and TXDATA write -> write accepted, overflow stays 0, count remains 4.
